gen_mc: RTL and testbench
=========================

Name: gen_mc

Overview:
- Multi-channel successor to the single-channel DDS generator.
- CHANNELS independent phase accumulators share one sine_rom, which is time-multiplexed round-robin.
- Each channel has amplitude scaling, optional inversion and a first-order sigma-delta bitstream output.
- Configured and read back over an Avalon-MM slave port. Sits between the CPU bus and the analog output pins.

Parameters:
- CHANNELS, 4, number of channels (power of two, 2..16).
- ACC_WIDTH, 16, phase accumulator width (>= 8). ROM address = acc[ACC_WIDTH-1 -: 8].
- ADDR_WIDTH, $clog2(CHANNELS)+2, Avalon address width.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- address  in  ADDR_WIDTH  register address: {channel, reg[1:0]}.
- write  in  1  Avalon write strobe, active-high.
- writedata  in  32  write data.
- read  in  1  Avalon read strobe, active-high.
- readdata  out  32  read data, valid the cycle after read.
- fout  out  CHANNELS  per-channel sigma-delta bitstreams.
- sync  out  1  one-cycle pulse on channel-0 accumulator wrap.

Behaviour:
- Reset: clr is sampled on posedge clk only.
  - Registers: PHINC=0, PHOFS=0, CTRL=0x0000FF00 (disabled, non-inverted, AMP=0xFF).
  - Pipeline and state: accumulators=0, held values=0, SD accumulators=0, sequencer=0.
  - Outputs: readdata=0, fout=0, sync=0.
- Register map per channel c, reg index r:
  - r=0 PHINC: bits[ACC_WIDTH-1:0], R/W.
  - r=1 PHOFS: bits[7:0], R/W. Added to the ROM address modulo 256.
  - r=2 CTRL: bit0 EN, bit1 INV, bits[15:8] AMP, R/W. Unused bits read 0.
  - r=3 STATUS: read-only, bits[7:0] = current acc[ACC_WIDTH-1 -: 8]. Writes ignored.
- Bus:
  - No waitrequest.
  - Write takes effect on the clock edge where write=1.
  - readdata registered, valid the cycle after read=1, holds its value otherwise.
  - read and write to the same address in the same cycle: readdata returns the old value.
- Accumulators: every cycle, for each channel with EN=1, acc <= acc + PHINC (wraps mod 2^ACC_WIDTH). A new PHINC is used from the cycle after the write. EN=0 holds acc.
- Sequencer: sel counts 0..CHANNELS-1 and wraps; it runs every cycle regardless of EN.
  - Stage 0: ROM address = acc[sel][ACC_WIDTH-1 -: 8] + PHOFS[sel].
  - Stage 1: sine_rom q is registered (1-cycle latency). q is unsigned offset binary, 8 bits.
  - Stage 2: s = INV ? 255-q : q; scaled = (s*AMP)>>8 (8 bits). Written to held[sel] delayed by 2 cycles.
  - Each held value refreshes once every CHANNELS cycles.
- Sigma-delta, per channel every cycle: {carry, sd[7:0]} <= sd + held. fout[c] = registered carry. Mean density = held/256.
- EN=0: held forced to 0, sd cleared, fout[c]=0 from the next edge. Re-enable resumes from the held accumulator value.
- sync: 1 for exactly one cycle when channel 0 has EN=1 and its accumulator addition carries out of bit ACC_WIDTH-1.
- Reset mid-operation: all state returns to reset values on that edge. No partial pipeline results survive.

Test Plan:
- Reset: drive clr 3 cycles.
  - fout=0, sync=0.
  - Read ch2 CTRL -> 0x0000FF00.
  - Read any PHINC -> 0.
- Bus:
  - Write ch1 PHINC=0x1234, read back -> 0x00001234 one cycle after read.
  - Write ch1 STATUS=0xFFFFFFFF, read back -> unchanged.
  - Write CTRL=0xFFFFFFFF, read back -> 0x0000FF03.
- Sweep (ACC_WIDTH=16): ch0 PHINC=0x0100, EN=1.
  - STATUS increments by 1 per cycle.
  - sync pulses every 256 cycles.
  - fout[0] ones over 4096 cycles = 2048±40.
- DC/amplitude: ch3 PHINC=0, PHOFS=64 (q=255), EN=1.
  - AMP=0xFF -> held=254, fout[3] ones in 256 cycles = 254±1.
  - AMP=0x80 -> 127±1.
  - INV=1 -> fout[3] stays 0 after 2*CHANNELS+2 cycles.
- Channel isolation: all four channels enabled with different PHINC values.
  - Each STATUS advances by its own PHINC>>8.
  - Disabling ch1 mid-run gives fout[1]=0 next cycle; the other channels are unaffected.
  - Re-enabling ch1 resumes STATUS from its frozen value.
- Reset mid-run: assert clr 1 cycle during the sweep.
  - All registers read back as reset values.
  - fout=0, sync stays 0 until reconfigured.

Source files
------------

// File: rtl/gen_mc.sv
// Multi-channel DDS generator: per-channel phase accumulators share one sine ROM
// in round-robin, then amplitude scaling, optional inversion and sigma-delta outputs.
module gen_mc #(
    parameter int CHANNELS   = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = $clog2(CHANNELS) + 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [CHANNELS-1:0]   fout,
    output logic                  sync
);
    localparam int CH_W = $clog2(CHANNELS);

    // First quarter of the wave (indices 0..64); the rest is mirrored from it.
    function automatic logic [7:0] quarter_sine(input logic [6:0] idx);
        logic [7:0] q;
        case (idx)
            7'd0:  q = 8'd128; 7'd1:  q = 8'd131; 7'd2:  q = 8'd134; 7'd3:  q = 8'd137;
            7'd4:  q = 8'd140; 7'd5:  q = 8'd143; 7'd6:  q = 8'd146; 7'd7:  q = 8'd149;
            7'd8:  q = 8'd152; 7'd9:  q = 8'd155; 7'd10: q = 8'd158; 7'd11: q = 8'd162;
            7'd12: q = 8'd165; 7'd13: q = 8'd167; 7'd14: q = 8'd170; 7'd15: q = 8'd173;
            7'd16: q = 8'd176; 7'd17: q = 8'd179; 7'd18: q = 8'd182; 7'd19: q = 8'd185;
            7'd20: q = 8'd188; 7'd21: q = 8'd190; 7'd22: q = 8'd193; 7'd23: q = 8'd196;
            7'd24: q = 8'd198; 7'd25: q = 8'd201; 7'd26: q = 8'd203; 7'd27: q = 8'd206;
            7'd28: q = 8'd208; 7'd29: q = 8'd211; 7'd30: q = 8'd213; 7'd31: q = 8'd215;
            7'd32: q = 8'd218; 7'd33: q = 8'd220; 7'd34: q = 8'd222; 7'd35: q = 8'd224;
            7'd36: q = 8'd226; 7'd37: q = 8'd228; 7'd38: q = 8'd230; 7'd39: q = 8'd232;
            7'd40: q = 8'd234; 7'd41: q = 8'd235; 7'd42: q = 8'd237; 7'd43: q = 8'd238;
            7'd44: q = 8'd240; 7'd45: q = 8'd241; 7'd46: q = 8'd243; 7'd47: q = 8'd244;
            7'd48: q = 8'd245; 7'd49: q = 8'd246; 7'd50: q = 8'd248; 7'd51: q = 8'd249;
            7'd52: q = 8'd250; 7'd53: q = 8'd250; 7'd54: q = 8'd251; 7'd55: q = 8'd252;
            7'd56: q = 8'd253; 7'd57: q = 8'd253; 7'd58: q = 8'd254; 7'd59: q = 8'd254;
            7'd60: q = 8'd254; 7'd61: q = 8'd255; 7'd62: q = 8'd255; 7'd63: q = 8'd255;
            default: q = 8'd255;
        endcase
        return q;
    endfunction

    function automatic logic [7:0] sine_lookup(input logic [7:0] a);
        logic [6:0] idx;
        logic [7:0] q;
        idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        q   = quarter_sine(idx);
        return a[7] ? (8'd255 - q) : q;
    endfunction

    logic [CH_W-1:0]                 bus_ch;
    logic [CH_W-1:0]                 sel_q;
    logic [CH_W-1:0]                 sel_p1_q;
    logic [7:0]                      rom_addr;
    logic [7:0]                      rom_q;
    logic [7:0]                      s_val;
    logic [15:0]                     product;
    logic [7:0]                      scaled;
    logic [CHANNELS-1:0][7:0]        acc_top;
    logic [CHANNELS-1:0][7:0]        phofs_all;
    logic [CHANNELS-1:0][7:0]        amp_all;
    logic [CHANNELS-1:0]             inv_all;
    logic [CHANNELS-1:0]             fout_all;
    logic [CHANNELS-1:0][3:0][31:0]  rd_view;
    logic                            ch0_wrap;
    logic [31:0]                     readdata_q;
    logic                            sync_q;
    logic                            unused_ok;

    assign bus_ch = address[ADDR_WIDTH-1:2];

    // Stage 0 address, stage 2 inversion and scaling for the channel whose ROM word is in rom_q.
    assign rom_addr = acc_top[sel_q] + phofs_all[sel_q];
    assign s_val    = inv_all[sel_p1_q] ? ~rom_q : rom_q;
    assign product  = {8'd0, s_val} * {8'd0, amp_all[sel_p1_q]};
    assign scaled   = product[15:8];

    assign unused_ok = ^{writedata, product[7:0]};

    always_ff @(posedge clk) begin
        if (clr) begin
            sel_q      <= '0;
            sel_p1_q   <= '0;
            rom_q      <= 8'd0;
            sync_q     <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            sel_q    <= sel_q + CH_W'(1);
            sel_p1_q <= sel_q;
            rom_q    <= sine_lookup(rom_addr);
            sync_q   <= ch0_wrap;
            if (read) begin
                readdata_q <= rd_view[bus_ch][address[1:0]];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [ACC_WIDTH-1:0] acc_q;
            logic [ACC_WIDTH-1:0] phinc_q;
            logic [ACC_WIDTH:0]   acc_sum;
            logic [7:0]           phofs_q;
            logic [7:0]           amp_q;
            logic [7:0]           held_q;
            logic [7:0]           sd_q;
            logic [8:0]           sd_sum;
            logic                 en_q;
            logic                 inv_q;
            logic                 fout_q;
            logic                 bus_hit;
            logic                 pipe_hit;

            assign acc_sum  = {1'b0, acc_q} + {1'b0, phinc_q};
            assign sd_sum   = {1'b0, sd_q} + {1'b0, held_q};
            assign bus_hit  = write && (bus_ch == CH_W'(gi));
            assign pipe_hit = (sel_p1_q == CH_W'(gi));

            always_ff @(posedge clk) begin
                if (clr) begin
                    acc_q   <= '0;
                    phinc_q <= '0;
                    phofs_q <= 8'd0;
                    amp_q   <= 8'hFF;
                    en_q    <= 1'b0;
                    inv_q   <= 1'b0;
                    held_q  <= 8'd0;
                    sd_q    <= 8'd0;
                    fout_q  <= 1'b0;
                end else begin
                    if (en_q) begin
                        acc_q <= acc_sum[ACC_WIDTH-1:0];
                    end
                    if (bus_hit) begin
                        case (address[1:0])
                            2'd0: phinc_q <= writedata[ACC_WIDTH-1:0];
                            2'd1: phofs_q <= writedata[7:0];
                            2'd2: begin
                                en_q  <= writedata[0];
                                inv_q <= writedata[1];
                                amp_q <= writedata[15:8];
                            end
                            default: ;
                        endcase
                    end
                    // A disabled channel parks its modulator so it restarts cleanly.
                    if (!en_q) begin
                        held_q <= 8'd0;
                        sd_q   <= 8'd0;
                        fout_q <= 1'b0;
                    end else begin
                        if (pipe_hit) begin
                            held_q <= scaled;
                        end
                        sd_q   <= sd_sum[7:0];
                        fout_q <= sd_sum[8];
                    end
                end
            end

            assign acc_top[gi]   = acc_q[ACC_WIDTH-1 -: 8];
            assign phofs_all[gi] = phofs_q;
            assign amp_all[gi]   = amp_q;
            assign inv_all[gi]   = inv_q;
            assign fout_all[gi]  = fout_q;
            assign rd_view[gi]   = {24'd0, acc_q[ACC_WIDTH-1 -: 8],
                                    16'd0, amp_q, 6'd0, inv_q, en_q,
                                    24'd0, phofs_q,
                                    32'(phinc_q)};

            if (gi == 0) begin : g_sync
                assign ch0_wrap = en_q & acc_sum[ACC_WIDTH];
            end
        end
    endgenerate

    assign readdata = readdata_q;
    assign fout     = fout_all;
    assign sync     = sync_q;

endmodule

// File: tb/tb_gen_mc.sv
// Directed bench for gen_mc: bus map, sweep, DC amplitude, channel isolation and reset.
`timescale 1ns/1ps
module tb_gen_mc;
    localparam int CHANNELS   = 4;
    localparam int ACC_WIDTH  = 16;
    localparam int ADDR_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  clr;
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic [31:0]           writedata;
    logic                  read;
    logic [31:0]           readdata;
    logic [CHANNELS-1:0]   fout;
    logic                  sync;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    gen_mc #(
        .CHANNELS  (CHANNELS),
        .ACC_WIDTH (ACC_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .read     (read),
        .readdata (readdata),
        .fout     (fout),
        .sync     (sync)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total_cnt++;
        assert (obs >= lo && obs <= hi) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
        $display("wr   addr=0x%h data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
        $display("rd   addr=0x%h data=0x%08h", a, d);
    endtask

    task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
        address = a; writedata = wd; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        d = readdata;
        $display("rdwr addr=0x%h wdata=0x%08h rdata=0x%08h", a, wd, d);
    endtask

    task automatic count_ones(input int ch, input int cycles, output int ones);
        ones = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            ones += int'(fout[ch]);
        end
        $display("cnt  ch=%0d cycles=%0d ones=%0d", ch, cycles, ones);
    endtask

    initial begin
        logic [31:0] rd, v1, v2;
        logic [3:0]  a;
        int ones, pulses, last_pulse, bad_gap;
        int incr [4] = '{1, 3, 5, 7};

        clr = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
        repeat (3) tick();
        check("rst_fout", 32'(fout), 32'd0);
        check("rst_sync", 32'(sync), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        clr = 1'b0;

        bus_read(4'hA, rd); check("rst_ch2_ctrl", rd, 32'h0000FF00);
        bus_read(4'h0, rd); check("rst_ch0_phinc", rd, 32'd0);
        bus_read(4'hC, rd); check("rst_ch3_phinc", rd, 32'd0);

        // Register map
        bus_write(4'h4, 32'h1234);
        bus_read(4'h4, rd); check("ch1_phinc_rb", rd, 32'h00001234);
        tick();             check("readdata_hold", readdata, 32'h00001234);
        bus_write(4'h7, 32'hFFFFFFFF);
        bus_read(4'h7, rd); check("ch1_status_ro", rd, 32'd0);
        bus_rw(4'h5, 32'h55, rd); check("rw_same_old", rd, 32'd0);
        bus_read(4'h5, rd); check("rw_same_new", rd, 32'h00000055);
        bus_write(4'h6, 32'hFFFFFFFF);
        bus_read(4'h6, rd); check("ctrl_mask", rd, 32'h0000FF03);
        bus_write(4'h6, 32'h0000FF00);
        bus_write(4'h5, 32'h0);

        // Sweep on channel 0
        bus_write(4'h0, 32'h0100);
        bus_write(4'h2, 32'h0000FF01);
        for (int k = 0; k < 4; k++) begin
            bus_read(4'h3, rd);
            check($sformatf("sweep_status%0d", k), rd, 32'(k));
        end
        ones = 0; pulses = 0; last_pulse = -1; bad_gap = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(fout[0]);
            if (sync) begin
                if (last_pulse >= 0 && (i - last_pulse) != 256) bad_gap++;
                last_pulse = i;
                pulses++;
            end
        end
        $display("swp  ones=%0d pulses=%0d bad_gaps=%0d", ones, pulses, bad_gap);
        check("sync_pulses", 32'(pulses), 32'd16);
        check("sync_gaps", 32'(bad_gap), 32'd0);
        check_range("fout0_density", ones, 2008, 2088);

        // DC level on channel 3: address 64 gives the ROM peak
        bus_write(4'hD, 32'd64);
        bus_write(4'hE, 32'h0000FF01);
        repeat (2 * CHANNELS + 4) tick();
        count_ones(3, 256, ones); check_range("dc_amp_ff", ones, 253, 255);
        bus_write(4'hE, 32'h00008001);
        repeat (2 * CHANNELS + 4) tick();
        count_ones(3, 256, ones); check_range("dc_amp_80", ones, 126, 128);
        bus_write(4'hE, 32'h0000FF03);
        repeat (2 * CHANNELS + 2) tick();
        count_ones(3, 64, ones); check("dc_inv_zero", 32'(ones), 32'd0);

        // Channel isolation
        bus_write(4'h4, 32'h0300);
        bus_write(4'h8, 32'h0500);
        bus_write(4'hC, 32'h0700);
        bus_write(4'h6, 32'h0000FF01);
        bus_write(4'hA, 32'h0000FF01);
        bus_write(4'hE, 32'h0000FF01);
        for (int c = 0; c < 4; c++) begin
            a = 4'(c * 4 + 3);
            bus_read(a, v1);
            bus_read(a, v2);
            check($sformatf("iso_step_ch%0d", c), (v2 - v1) & 32'hFF, 32'(incr[c]));
        end
        bus_write(4'h6, 32'h0000FF00);
        tick();
        check("ch1_off_fout", 32'(fout[1]), 32'd0);
        count_ones(1, 32, ones); check("ch1_off_quiet", 32'(ones), 32'd0);
        for (int c = 0; c < 4; c++) begin
            a = 4'(c * 4 + 3);
            bus_read(a, v1);
            bus_read(a, v2);
            check($sformatf("iso_off_step_ch%0d", c), (v2 - v1) & 32'hFF,
                  (c == 1) ? 32'd0 : 32'(incr[c]));
        end
        bus_read(4'h7, v1);
        bus_write(4'h6, 32'h0000FF01);
        bus_read(4'h7, v2); check("ch1_resume", v2, v1);
        bus_read(4'h7, rd); check("ch1_resume_step", (rd - v1) & 32'hFF, 32'd3);

        // Reset in the middle of the run
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid_rst_fout", 32'(fout), 32'd0);
        check("mid_rst_sync", 32'(sync), 32'd0);
        check("mid_rst_readdata", readdata, 32'd0);
        for (int c = 0; c < 4; c++) begin
            bus_read(4'(c * 4 + 0), rd); check($sformatf("mid_rst_phinc%0d", c), rd, 32'd0);
            bus_read(4'(c * 4 + 1), rd); check($sformatf("mid_rst_phofs%0d", c), rd, 32'd0);
            bus_read(4'(c * 4 + 2), rd); check($sformatf("mid_rst_ctrl%0d", c), rd, 32'h0000FF00);
            bus_read(4'(c * 4 + 3), rd); check($sformatf("mid_rst_status%0d", c), rd, 32'd0);
        end
        pulses = 0; ones = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            pulses += int'(sync);
            ones   += $countones(fout);
        end
        $display("post ones=%0d pulses=%0d", ones, pulses);
        check("post_rst_sync", 32'(pulses), 32'd0);
        check("post_rst_fout", 32'(ones), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
